rd_ctrl_mc: RTL and testbench



---
 rtl/rd_ctrl_pkg.sv | 29 ++
 rtl/rd_ctrl_mc_if.sv | 66 ++++++
 rtl/rd_rsp_fifo.sv | 54 +++++
 rtl/rd_ctrl_mc.sv | 188 ++++++++++++++++++
 tb/tb_rd_ctrl_mc.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rd_ctrl_pkg.sv
// rtl/rd_ctrl_pkg.sv - shared state, command and status definitions for rd_ctrl_mc
package rd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_ALLOCATE,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_UPDATE,
    ST_BURST
  } state_e;

  localparam logic [2:0] CMD_NONE   = 3'b000;
  localparam logic [2:0] CMD_LOOKUP = 3'b001;
  localparam logic [2:0] CMD_ALLOC  = 3'b010;
  localparam logic [2:0] CMD_UPDATE = 3'b011;

  localparam logic [2:0] STS_MISS = 3'b000;
  localparam logic [2:0] STS_BUSY = 3'b100;

  function automatic logic is_hit(input logic [2:0] status);
    case (status)
      3'b001, 3'b010, 3'b011, 3'b110: is_hit = 1'b1;
      default:                        is_hit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rd_ctrl_mc_if.sv
// rtl/rd_ctrl_mc_if.sv - accessor, list, fetch and line-memory signals of rd_ctrl_mc
interface rd_ctrl_mc_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LIST_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int MAX_BURST  = 8
);
  localparam int TAG_W = $clog2(LIST_DEPTH);
  localparam int WO_W  = $clog2(LIST_WIDTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LEN_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [NUM_CH-1:0]        ch_rd_valid;
  logic [NUM_CH-1:0]        ch_rd_ready;
  logic [NUM_CH*ADDR_W-1:0] ch_rd_addr;
  logic [NUM_CH*LEN_W-1:0]  ch_rd_len;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_data_valid;
  logic [CH_W-1:0]          rd_data_ch;
  logic                     rd_data_last;

  logic                     acc_req;
  logic                     acc_gnt;
  logic [2:0]               acc_cmd;
  logic [ADDR_W-1:0]        acc_index;
  logic [TAG_W-1:0]         acc_tag;
  logic [2:0]               acc_status;
  logic [TAG_W-1:0]         return_tag;

  logic                     fetch_req;
  logic                     fetch_gnt;
  logic [ADDR_W-1:0]        fetch_addr;
  logic [TAG_W-1:0]         fetch_tag;
  logic                     fetch_done;

  logic                     mem_ren;
  logic                     mem_rready;
  logic [TAG_W+WO_W-1:0]    mem_raddr;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_rdata_valid;

  modport master (
    input  ch_rd_valid, ch_rd_addr, ch_rd_len,
    output ch_rd_ready, rd_data, rd_data_valid, rd_data_ch, rd_data_last,
    output acc_req, acc_cmd, acc_index, acc_tag,
    input  acc_gnt, acc_status, return_tag,
    output fetch_req, fetch_addr, fetch_tag,
    input  fetch_gnt, fetch_done,
    output mem_ren, mem_raddr,
    input  mem_rready, mem_rdata, mem_rdata_valid
  );

  modport slave (
    output ch_rd_valid, ch_rd_addr, ch_rd_len,
    input  ch_rd_ready, rd_data, rd_data_valid, rd_data_ch, rd_data_last,
    input  acc_req, acc_cmd, acc_index, acc_tag,
    output acc_gnt, acc_status, return_tag,
    input  fetch_req, fetch_addr, fetch_tag,
    output fetch_gnt, fetch_done,
    input  mem_ren, mem_raddr,
    output mem_rready, mem_rdata, mem_rdata_valid
  );

endinterface

// File: rtl/rd_rsp_fifo.sv
// rtl/rd_rsp_fifo.sv - in-order tracker of {channel, last} for outstanding line-memory reads
module rd_rsp_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_pop     = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rd_ctrl_mc.sv
// rtl/rd_ctrl_mc.sv - round-robin multi-channel cache read controller with wrapping bursts
module rd_ctrl_mc
  import rd_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LIST_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int MAX_BURST  = 8,
  parameter int RSP_DEPTH  = 4
) (
  input logic          clk,
  input logic          rst,
  rd_ctrl_mc_if.master bus
);
  localparam int TAG_W = $clog2(LIST_DEPTH);
  localparam int WO_W  = $clog2(LIST_WIDTH);
  localparam int BO_W  = $clog2(LIST_WIDTH * DATA_W / 8);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LEN_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int LN_W  = ADDR_W - BO_W;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_q, rr_d, ch_q, ch_d;
  logic [LN_W-1:0]   line_q, line_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WO_W-1:0]   woff_q, woff_d;

  logic              win_vld;
  logic [CH_W-1:0]   win_ch, cand;
  logic [ADDR_W-1:0] addr_sel;
  logic [LEN_W-1:0]  len_sel;
  logic [ADDR_W-1:0] line_addr;
  logic              last_word, push;
  logic              fifo_full, fifo_empty, fifo_last, pop;
  logic [CH_W-1:0]   fifo_ch;

  // Scan from rr_q upward so the channel after the last winner gets first pick.
  always_comb begin
    win_vld = 1'b0;
    win_ch  = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((int'(rr_q) + i) % NUM_CH);
      if (!win_vld && bus.ch_rd_valid[cand]) begin
        win_vld = 1'b1;
        win_ch  = cand;
      end
    end
  end

  assign addr_sel  = bus.ch_rd_addr[win_ch*ADDR_W +: ADDR_W];
  assign len_sel   = bus.ch_rd_len[win_ch*LEN_W +: LEN_W];
  assign line_addr = {line_q, {BO_W{1'b0}}};
  assign last_word = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    line_d  = line_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    woff_d  = woff_q;
    push    = 1'b0;
    bus.ch_rd_ready = '0;
    bus.acc_req     = 1'b0;
    bus.acc_cmd     = CMD_NONE;
    bus.acc_index   = '0;
    bus.acc_tag     = '0;
    bus.fetch_req   = 1'b0;
    bus.fetch_addr  = '0;
    bus.fetch_tag   = '0;
    bus.mem_ren     = 1'b0;
    bus.mem_raddr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          bus.ch_rd_ready[win_ch] = 1'b1;
          ch_d    = win_ch;
          line_d  = addr_sel[ADDR_W-1:BO_W];
          len_d   = len_sel;
          cnt_d   = '0;
          woff_d  = addr_sel[BO_W-1 -: WO_W];
          rr_d    = (win_ch == CH_W'(NUM_CH - 1)) ? '0 : win_ch + 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        bus.acc_req   = 1'b1;
        bus.acc_cmd   = CMD_LOOKUP;
        bus.acc_index = line_addr;
        // Busy and unrecognised codes leave the lookup asserted for a retry.
        if (bus.acc_gnt) begin
          if (is_hit(bus.acc_status)) begin
            tag_d   = bus.return_tag;
            state_d = ST_BURST;
          end else if (bus.acc_status == STS_MISS) begin
            state_d = ST_ALLOCATE;
          end
        end
      end
      ST_ALLOCATE: begin
        bus.acc_req   = 1'b1;
        bus.acc_cmd   = CMD_ALLOC;
        bus.acc_index = line_addr;
        if (bus.acc_gnt) begin
          tag_d   = bus.return_tag;
          state_d = ST_FETCH_REQ;
        end
      end
      ST_FETCH_REQ: begin
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = line_addr;
        bus.fetch_tag  = tag_q;
        if (bus.fetch_gnt) state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        if (bus.fetch_done) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        bus.acc_req   = 1'b1;
        bus.acc_cmd   = CMD_UPDATE;
        bus.acc_index = line_addr;
        bus.acc_tag   = tag_q;
        if (bus.acc_gnt) state_d = ST_BURST;
      end
      ST_BURST: begin
        bus.mem_ren   = !fifo_full;
        bus.mem_raddr = {tag_q, woff_q};
        if (!fifo_full && bus.mem_rready) begin
          push   = 1'b1;
          woff_d = woff_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (last_word) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      ch_q    <= '0;
      line_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      woff_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      line_q  <= line_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      woff_q  <= woff_d;
    end
  end

  rd_rsp_fifo #(
    .WIDTH (CH_W + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({ch_q, last_word}),
    .pop_i       (pop),
    .pop_data_o  ({fifo_ch, fifo_last}),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Data with no tracked read behind it (e.g. issued before a reset) is dropped.
  assign pop               = bus.mem_rdata_valid && !fifo_empty;
  assign bus.rd_data       = bus.mem_rdata;
  assign bus.rd_data_valid = pop;
  assign bus.rd_data_ch    = pop ? fifo_ch : '0;
  assign bus.rd_data_last  = pop && fifo_last;

endmodule

// File: tb/tb_rd_ctrl_mc.sv
// tb/tb_rd_ctrl_mc.sv - directed self-checking bench for rd_ctrl_mc
module tb_rd_ctrl_mc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rd_ctrl_mc_if bus ();
  rd_ctrl_mc dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int mem_lat = 1;
  int fetch_dly = 10;
  int fcnt = 0;
  int max_infl = 0;
  int vld_cnt = 0;

  logic [4:0]  acc_script[$];
  int          acc_cyc[$];
  logic [2:0]  acc_cmd_l[$];
  logic [31:0] acc_idx_l[$];
  logic [1:0]  acc_tag_l[$];
  int          acpt_cyc[$];
  int          acpt_ch[$];
  int          f_cyc[$];
  logic [31:0] f_addr_l[$];
  logic [1:0]  f_tag_l[$];
  int          iss_cyc[$];
  logic [6:0]  iss_addr[$];
  int          pend_due[$];
  logic [6:0]  pend_addr[$];
  logic [31:0] got_data[$];
  int          got_ch[$];
  logic        got_last[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Environment: list, fetch and memory responders plus output logging.
  always @(negedge clk) begin
    logic [4:0] e;
    cyc++;
    for (int i = 0; i < 2; i++)
      if (bus.ch_rd_valid[i] && bus.ch_rd_ready[i]) begin
        acpt_cyc.push_back(cyc);
        acpt_ch.push_back(i);
      end
    if (bus.acc_req && (bus.acc_cmd == 3'b011 || acc_script.size() > 0)) begin
      e = (bus.acc_cmd == 3'b011) ? 5'd0 : acc_script.pop_front();
      bus.acc_gnt    = 1'b1;
      bus.acc_status = e[4:2];
      bus.return_tag = e[1:0];
      acc_cyc.push_back(cyc);
      acc_cmd_l.push_back(bus.acc_cmd);
      acc_idx_l.push_back(bus.acc_index);
      acc_tag_l.push_back(bus.acc_tag);
    end else begin
      bus.acc_gnt    = 1'b0;
      bus.acc_status = 3'b000;
      bus.return_tag = 2'd0;
    end
    bus.fetch_done = 1'b0;
    if (fcnt > 0) begin
      fcnt--;
      if (fcnt == 0) bus.fetch_done = 1'b1;
    end
    bus.fetch_gnt = bus.fetch_req;
    if (bus.fetch_req) begin
      f_cyc.push_back(cyc);
      f_addr_l.push_back(bus.fetch_addr);
      f_tag_l.push_back(bus.fetch_tag);
      fcnt = fetch_dly;
    end
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = 32'd0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      void'(pend_due.pop_front());
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = 32'hA5A5_0000 | 32'(pend_addr.pop_front());
    end
    if (bus.mem_ren && bus.mem_rready) begin
      iss_cyc.push_back(cyc);
      iss_addr.push_back(bus.mem_raddr);
      pend_due.push_back(cyc + mem_lat);
      pend_addr.push_back(bus.mem_raddr);
      if (pend_due.size() > max_infl) max_infl = pend_due.size();
    end
    #1;
    if (bus.rd_data_valid) begin
      vld_cnt++;
      got_data.push_back(bus.rd_data);
      got_ch.push_back(int'(bus.rd_data_ch));
      got_last.push_back(bus.rd_data_last);
    end
  end

  task automatic clr();
    acc_cyc.delete(); acc_cmd_l.delete(); acc_idx_l.delete(); acc_tag_l.delete();
    acpt_cyc.delete(); acpt_ch.delete(); f_cyc.delete(); f_addr_l.delete(); f_tag_l.delete();
    iss_cyc.delete(); iss_addr.delete(); got_data.delete(); got_ch.delete(); got_last.delete();
    max_infl = 0;
  endtask

  task automatic req(input int ch, input logic [31:0] addr, input int len);
    int n;
    int k;
    @(posedge clk); #1;
    bus.ch_rd_addr[ch*32 +: 32] = addr;
    bus.ch_rd_len[ch*3 +: 3]    = len[2:0];
    bus.ch_rd_valid[ch]         = 1'b1;
    n = acpt_ch.size();
    for (k = 0; k < 50 && acpt_ch.size() == n; k++) begin
      @(posedge clk); #1;
    end
    bus.ch_rd_valid[ch] = 1'b0;
    chk("accept_timeout", acpt_ch.size(), n + 1);
  endtask

  task automatic wait_got(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && got_data.size() < n; k++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(tag, got_data.size(), n);
  endtask

  logic [6:0] exp_a[8];
  logic [4:0] ex_ch_last[6];
  logic [6:0] ex4_addr[6];
  int k;

  initial begin
    rst = 1'b1;
    bus.ch_rd_valid = '0;
    bus.ch_rd_addr  = '0;
    bus.ch_rd_len   = '0;
    bus.mem_rready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.ch_rd_ready, 0);
    chk("rst_acc_req", bus.acc_req, 0);
    chk("rst_mem_ren", bus.mem_ren, 0);
    chk("rst_fetch_req", bus.fetch_req, 0);
    chk("rst_rd_valid", bus.rd_data_valid, 0);
    rst = 1'b0;

    // single hit: tag 2, word 16
    clr();
    acc_script.push_back({3'b001, 2'd2});
    req(0, 32'h40, 0);
    wait_got("hit_wait", 1, 50);
    chk("hit_raddr", iss_addr[0], 7'h50);
    chk("hit_nissue", iss_addr.size(), 1);
    chk("hit_ch", got_ch[0], 0);
    chk("hit_last", got_last[0], 1);
    chk("hit_data", got_data[0], 32'hA5A5_0050);
    chk("hit_cmd", acc_cmd_l[0], 3'b001);
    chk("hit_index", acc_idx_l[0], 32'h0);
    chk("hit_lookup_lat", acc_cyc[0] - acpt_cyc[0], 1);
    chk("hit_ren_lat", iss_cyc[0] - acpt_cyc[0], 2);

    // wrap burst on ch1: words 30,31,0,1 of tag 3
    clr();
    acc_script.push_back({3'b010, 2'd3});
    req(1, 32'h78, 3);
    wait_got("wrap_wait", 4, 50);
    exp_a[0] = 7'd126; exp_a[1] = 7'd127; exp_a[2] = 7'd96; exp_a[3] = 7'd97;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_raddr%0d", i), iss_addr[i], exp_a[i]);
      chk($sformatf("wrap_last%0d", i), got_last[i], (i == 3) ? 1 : 0);
    end
    chk("wrap_ch", got_ch[3], 1);

    // miss, allocate tag 1, fetch, update; line of 0xC8 is 0x80, word 18
    clr();
    acc_script.push_back({3'b000, 2'd0});
    acc_script.push_back({3'b000, 2'd1});
    req(1, 32'hC8, 1);
    wait_got("miss_wait", 2, 100);
    chk("miss_cmd0", acc_cmd_l[0], 3'b001);
    chk("miss_cmd1", acc_cmd_l[1], 3'b010);
    chk("miss_cmd2", acc_cmd_l[2], 3'b011);
    chk("miss_index", acc_idx_l[0], 32'h80);
    chk("miss_upd_tag", acc_tag_l[2], 1);
    chk("miss_fetch_addr", f_addr_l[0], 32'h80);
    chk("miss_fetch_tag", f_tag_l[0], 1);
    chk("miss_fetch_to_upd", acc_cyc[2] - f_cyc[0], 11);
    chk("miss_upd_to_ren", iss_cyc[0] - acc_cyc[2], 1);
    chk("miss_raddr0", iss_addr[0], 7'd50);
    chk("miss_raddr1", iss_addr[1], 7'd51);

    // both channels continuously valid: grants 0,1,0,1
    clr();
    acc_script.push_back({3'b011, 2'd0});
    acc_script.push_back({3'b110, 2'd1});
    acc_script.push_back({3'b001, 2'd2});
    acc_script.push_back({3'b001, 2'd3});
    @(posedge clk); #1;
    bus.ch_rd_addr = {32'h104, 32'h0};
    bus.ch_rd_len  = {3'd0, 3'd1};
    bus.ch_rd_valid = 2'b11;
    for (k = 0; k < 200 && acpt_ch.size() < 4; k++) begin
      @(posedge clk); #1;
    end
    bus.ch_rd_valid = 2'b00;
    chk("rr_naccept", acpt_ch.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), acpt_ch[i], i % 2);
    wait_got("rr_wait", 6, 100);
    ex_ch_last[0] = {4'd0, 1'b0}; ex_ch_last[1] = {4'd0, 1'b1}; ex_ch_last[2] = {4'd1, 1'b1};
    ex_ch_last[3] = {4'd0, 1'b0}; ex_ch_last[4] = {4'd0, 1'b1}; ex_ch_last[5] = {4'd1, 1'b1};
    ex4_addr[0] = 7'd0;  ex4_addr[1] = 7'd1;  ex4_addr[2] = 7'd33;
    ex4_addr[3] = 7'd64; ex4_addr[4] = 7'd65; ex4_addr[5] = 7'd97;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_ch_last%0d", i), {got_ch[i][3:0], got_last[i]}, ex_ch_last[i]);
      chk($sformatf("rr_raddr%0d", i), iss_addr[i], ex4_addr[i]);
    end

    // busy three times, then hit tag 1 at word 4
    clr();
    repeat (3) acc_script.push_back({3'b100, 2'd0});
    acc_script.push_back({3'b001, 2'd1});
    req(0, 32'h10, 0);
    wait_got("busy_wait", 1, 50);
    chk("busy_nlookup", acc_cyc.size(), 4);
    chk("busy_span", acc_cyc[3] - acc_cyc[0], 3);
    chk("busy_cmd3", acc_cmd_l[3], 3'b001);
    chk("busy_ren_lat", iss_cyc[0] - acc_cyc[3], 1);
    chk("busy_data", got_data[0], 32'hA5A5_0024);
    chk("busy_last", got_last[0], 1);

    // slow memory: 5-cycle latency, len 7 from word 31 of tag 2
    clr();
    mem_lat = 5;
    acc_script.push_back({3'b001, 2'd2});
    req(0, 32'h7C, 7);
    wait_got("slow_wait", 8, 200);
    chk("slow_max_inflight", max_infl, 4);
    chk("slow_stall_gap", iss_cyc[4] - iss_cyc[3], 3);
    exp_a[0] = 7'd95;
    for (int i = 1; i < 8; i++) exp_a[i] = 7'(63 + i);
    for (int i = 0; i < 8; i++)
      chk($sformatf("slow_data%0d", i), got_data[i], 32'hA5A5_0000 | 32'(exp_a[i]));
    chk("slow_last6", got_last[6], 0);
    chk("slow_last7", got_last[7], 1);

    // reset in the middle of a burst
    clr();
    acc_script.push_back({3'b001, 2'd0});
    req(0, 32'h0, 7);
    for (k = 0; k < 50 && iss_addr.size() < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("mid_rst_issued", iss_addr.size() >= 3, 1);
    rst = 1'b1;
    vld_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_ren", bus.mem_ren, 0);
    chk("mid_rst_acc_req", bus.acc_req, 0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_rst_no_stray", vld_cnt, 0);
    chk("mid_rst_idle_ren", bus.mem_ren, 0);

    // after reset rr_ptr is 0 again: ch0 wins
    clr();
    mem_lat = 1;
    acc_script.delete();
    acc_script.push_back({3'b001, 2'd1});
    @(posedge clk); #1;
    bus.ch_rd_addr  = {32'h20, 32'h8};
    bus.ch_rd_len   = 6'd0;
    bus.ch_rd_valid = 2'b11;
    for (k = 0; k < 50 && acpt_ch.size() < 1; k++) begin
      @(posedge clk); #1;
    end
    bus.ch_rd_valid = 2'b00;
    chk("post_rst_grant", acpt_ch[0], 0);
    wait_got("post_rst_wait", 1, 50);
    chk("post_rst_raddr", iss_addr[0], 7'd34);
    chk("post_rst_ch", got_ch[0], 0);
    chk("post_rst_last", got_last[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
